// File: rtl/imem_port_arbiter.sv
// Arbitrates the single instruction-memory read port between the I-cache refill
// burst path and CPU data-path loads; atomic bursts, round-robin on ties.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rf_req,
  input  logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [3:0]            rf_burst_len,
  output logic                  rf_gnt,
  output logic [DATA_WIDTH-1:0] rf_data,
  output logic                  rf_valid,
  output logic                  rf_last,
  input  logic                  dp_req,
  input  logic [ADDR_WIDTH-1:0] dp_addr,
  output logic                  dp_gnt,
  output logic [DATA_WIDTH-1:0] dp_data,
  output logic                  dp_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_DATA   = 2'd2
  } state_e;

  localparam int                  OFF_BITS = $clog2(BLOCK_SIZE * 4);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
    ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));
  localparam logic [3:0]          MAX_LEN  = 4'(BLOCK_SIZE - 1);

  state_e                  state_q;
  logic                    last_rf_q;
  logic [3:0]              beat_cnt_q;
  logic [3:0]              len_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   rf_data_q;
  logic [DATA_WIDTH-1:0]   dp_data_q;
  logic                    rf_valid_q;
  logic                    rf_last_q;
  logic                    dp_valid_q;

  logic                    sel_rf;
  logic                    sel_dp;
  logic [3:0]              len_d;
  logic [ADDR_WIDTH-1:0]   base_d;
  logic [3:0]              beat_nxt;
  logic [ADDR_WIDTH-1:0]   beat_addr;

  // Handshake: a requester holds req (and its address) until it sees gnt=1;
  // the rising edge with req&&gnt is the acceptance edge, req drops after it.
  // gnt is only ever offered from IDLE, to at most one requester per cycle.
  always_comb begin
    sel_rf    = rf_req && (!dp_req || !last_rf_q);
    sel_dp    = dp_req && (!rf_req || last_rf_q);
    len_d     = (rf_burst_len > MAX_LEN) ? MAX_LEN : rf_burst_len;
    base_d    = rf_addr & BLK_MASK;
    beat_nxt  = beat_cnt_q + 4'd1;
    beat_addr = base_q + ADDR_WIDTH'({beat_nxt, 2'b00});
  end

  assign rf_gnt    = (state_q == S_IDLE) && sel_rf;
  assign dp_gnt    = (state_q == S_IDLE) && sel_dp;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
  assign mem_addr  = mem_addr_q;
  assign rf_data   = rf_data_q;
  assign rf_valid  = rf_valid_q;
  assign rf_last   = rf_last_q;
  assign dp_data   = dp_data_q;
  assign dp_valid  = dp_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      last_rf_q  <= 1'b0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      rf_data_q  <= '0;
      dp_data_q  <= '0;
      rf_valid_q <= 1'b0;
      rf_last_q  <= 1'b0;
      dp_valid_q <= 1'b0;
    end else begin
      rf_valid_q <= 1'b0;
      rf_last_q  <= 1'b0;
      dp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rf_gnt) begin
            state_q    <= S_REFILL;
            base_q     <= base_d;
            len_q      <= len_d;
            beat_cnt_q <= '0;
            mem_addr_q <= base_d;
            last_rf_q  <= 1'b1;
          end else if (dp_gnt) begin
            state_q    <= S_DATA;
            mem_addr_q <= dp_addr;
            last_rf_q  <= 1'b0;
          end
        end
        S_REFILL: begin
          rf_data_q  <= mem_rdata;
          rf_valid_q <= 1'b1;
          beat_cnt_q <= beat_nxt;
          // The final beat leaves mem_addr on the last word so it never leaves the block.
          if (beat_cnt_q == len_q) begin
            rf_last_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            mem_addr_q <= beat_addr;
          end
        end
        S_DATA: begin
          dp_data_q  <= mem_rdata;
          dp_valid_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: refill bursts, data reads, round-robin
// ties, busy-time requests, burst clamping and mid-burst reset.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        rf_req;
  logic [31:0] rf_addr;
  logic [3:0]  rf_burst_len;
  logic        rf_gnt;
  logic [31:0] rf_data;
  logic        rf_valid;
  logic        rf_last;
  logic        dp_req;
  logic [31:0] dp_addr;
  logic        dp_gnt;
  logic [31:0] dp_data;
  logic        dp_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_mis;
  logic [31:0] exp_q[$];

  imem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(8)) dut (
    .clk(clk), .rst(rst),
    .rf_req(rf_req), .rf_addr(rf_addr), .rf_burst_len(rf_burst_len),
    .rf_gnt(rf_gnt), .rf_data(rf_data), .rf_valid(rf_valid), .rf_last(rf_last),
    .dp_req(dp_req), .dp_addr(dp_addr), .dp_gnt(dp_gnt), .dp_data(dp_data),
    .dp_valid(dp_valid), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational instruction memory: every address has a distinct word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction
  assign mem_rdata = mem_word(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    rf_req = 1'b0; rf_addr = '0; rf_burst_len = '0;
    dp_req = 1'b0; dp_addr = '0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Drives one refill from IDLE and checks every beat against the block model.
  task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] exp_base, input int exp_beats);
    logic [31:0] last_word;
    int          a_idx;
    rf_req = 1'b1; rf_addr = addr; rf_burst_len = len;
    #1;
    check("rf_gnt", {31'd0, rf_gnt}, 32'd1);
    step();
    rf_req = 1'b0;
    check("e0_mem_addr", mem_addr, exp_base);
    check("e0_busy", {31'd0, busy}, 32'd1);
    check("e0_rf_valid", {31'd0, rf_valid}, 32'd0);
    for (int k = 0; k < exp_beats; k++) exp_q.push_back(mem_word(exp_base + 32'(4 * k)));
    for (int k = 0; k < exp_beats; k++) begin
      step();
      last_word = exp_q.pop_front();
      a_idx = (k + 1 < exp_beats) ? k + 1 : exp_beats - 1;
      check("beat_valid", {31'd0, rf_valid}, 32'd1);
      check("beat_data", rf_data, last_word);
      check("beat_last", {31'd0, rf_last}, (k == exp_beats - 1) ? 32'd1 : 32'd0);
      check("beat_mem_addr", mem_addr, exp_base + 32'(4 * a_idx));
    end
    check("post_busy", {31'd0, busy}, 32'd0);
    step();
    check("post_rf_valid", {31'd0, rf_valid}, 32'd0);
    check("post_rf_last", {31'd0, rf_last}, 32'd0);
    check("post_rf_hold", rf_data, last_word);
  endtask

  task automatic data_read(input logic [31:0] addr);
    dp_req = 1'b1; dp_addr = addr;
    #1;
    check("dp_gnt", {31'd0, dp_gnt}, 32'd1);
    step();
    dp_req = 1'b0;
    check("dp_e0_busy", {31'd0, busy}, 32'd1);
    check("dp_e0_mem_addr", mem_addr, addr);
    check("dp_e0_valid", {31'd0, dp_valid}, 32'd0);
    step();
    check("dp_valid", {31'd0, dp_valid}, 32'd1);
    check("dp_data", dp_data, mem_word(addr));
    check("dp_busy_done", {31'd0, busy}, 32'd0);
    step();
    check("dp_valid_drop", {31'd0, dp_valid}, 32'd0);
    check("dp_data_hold", dp_data, mem_word(addr));
  endtask

  initial begin
    int waited;
    bit seen;
    bit early;
    n_cmp = 0;
    n_mis = 0;

    // reset state
    apply_reset();
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rf_data", rf_data, 32'd0);
    check("rst_dp_data", dp_data, 32'd0);
    check("rst_valids", {29'd0, rf_valid, rf_last, dp_valid}, 32'd0);

    // 1: full block refill from an unaligned address
    run_burst(32'h0000_001C, 4'd7, 32'h0000_0000, 8);

    // 2: single data read
    data_read(32'h0000_0104);

    // 3: tie from reset -> refill first; repeated tie -> data first
    apply_reset();
    rf_req = 1'b1; rf_addr = 32'h200; rf_burst_len = 4'd0;
    dp_req = 1'b1; dp_addr = 32'h300;
    #1;
    check("tie1_rf_gnt", {31'd0, rf_gnt}, 32'd1);
    check("tie1_dp_gnt", {31'd0, dp_gnt}, 32'd0);
    step();
    rf_req = 1'b0;
    check("tie1_dp_blocked", {31'd0, dp_gnt}, 32'd0);
    step();
    check("tie1_beat", rf_data, mem_word(32'h200));
    check("tie1_last", {31'd0, rf_last}, 32'd1);
    rf_req = 1'b1; rf_addr = 32'h220; rf_burst_len = 4'd1;
    #1;
    check("tie2_dp_gnt", {31'd0, dp_gnt}, 32'd1);
    check("tie2_rf_gnt", {31'd0, rf_gnt}, 32'd0);
    step();
    dp_req = 1'b0;
    check("tie2_rf_wait", {31'd0, rf_gnt}, 32'd0);
    step();
    check("tie2_dp_valid", {31'd0, dp_valid}, 32'd1);
    check("tie2_dp_data", dp_data, mem_word(32'h300));
    check("tie2_rf_gnt_late", {31'd0, rf_gnt}, 32'd1);
    step();
    rf_req = 1'b0;
    step();
    check("tie2_b0", rf_data, mem_word(32'h220));
    check("tie2_b0_last", {31'd0, rf_last}, 32'd0);
    step();
    check("tie2_b1", rf_data, mem_word(32'h224));
    check("tie2_b1_last", {31'd0, rf_last}, 32'd1);
    step();

    // 4: data request raised during beat 3 waits for IDLE
    rf_req = 1'b1; rf_addr = 32'h40; rf_burst_len = 4'd7;
    step();
    rf_req = 1'b0;
    step(); step(); step();
    check("t4_beat3", rf_data, mem_word(32'h48));
    dp_req = 1'b1; dp_addr = 32'h0000_0510;
    waited = 0; seen = 1'b0; early = 1'b0;
    while (!seen && waited < 20) begin
      #1;
      if (dp_gnt) begin
        seen = 1'b1;
        if (busy) early = 1'b1;
      end else begin
        step();
        waited++;
      end
    end
    check("t4_gnt_seen", {31'd0, seen}, 32'd1);
    check("t4_gnt_while_busy", {31'd0, early}, 32'd0);
    check("t4_gnt_cycle", waited, 32'd5);
    step();
    dp_req = 1'b0;
    step();
    waited++;
    check("t4_dp_valid", {31'd0, dp_valid}, 32'd1);
    check("t4_dp_data", dp_data, mem_word(32'h510));
    check("t4_within_bound", {31'd0, (waited + 1) <= 10}, 32'd1);
    step();

    // 5: oversized burst length is clamped to the block
    run_burst(32'h0000_02C4, 4'd12, 32'h0000_02C0, 8);

    // 6: reset during beat 4 aborts the burst; next refill restarts at beat 0
    rf_req = 1'b1; rf_addr = 32'h80; rf_burst_len = 4'd7;
    step();
    rf_req = 1'b0;
    step(); step(); step(); step();
    check("t6_beat4", rf_data, mem_word(32'h8C));
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, rf_valid}, 32'd0);
    check("t6_rst_state", {30'd0, dbg_state}, 32'd0);
    check("t6_rst_mem_addr", mem_addr, 32'd0);
    step();
    rst = 1'b1;
    check("t6_no_beat", {31'd0, rf_valid}, 32'd0);
    run_burst(32'h0000_00A8, 4'd3, 32'h0000_00A0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
